led_scheduler: RTL and testbench
================================

LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 Parameter DWELL, default 4: number of clock cycles one grant is held; legal range 1..255; 0 SHALL behave as 1.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  scheduler enable, synchronous to clk.
REQ-005 sw  input  16  request lines, one per requester, asynchronous to clk; bit i high = requester i wants the LED bank.
REQ-006 led  output  16  registered one-hot display of the granted requester; all-zero when nothing is granted.
REQ-007 grant_valid  output  1  registered; high exactly while led is non-zero.
REQ-008 grant_idx  output  4  registered index of the current or most recent grant.

Function
REQ-009 sw SHALL pass through a 2-flop synchronizer per bit; sreq denotes the second-stage value; no other logic SHALL read sw directly.
REQ-010 FSM states SHALL be IDLE, GRANT and GAP.
REQ-011 IDLE: if enable=1 and sreq!=0, go to GRANT with the winner selected per REQ-013; otherwise stay in IDLE.
REQ-012 GRANT: dwell counter SHALL start at 0 on entry and increment each cycle. Go to GAP when any of the following holds: counter=DWELL-1; sreq[grant_idx]=0; enable=0.
REQ-013 Arbitration SHALL be round-robin: winner = first set bit of sreq scanning from (last_idx+1) mod 16 upward, wrapping 15->0; last_idx SHALL update to the winner on each GRANT entry.
REQ-014 GAP SHALL last exactly 1 cycle with led=0, then go to IDLE; IDLE SHALL re-arbitrate on the same edge if eligible (IDLE occupies 0 cycles when requests are pending).
REQ-015 In GRANT: led = 1<<grant_idx and grant_valid=1. In IDLE and GAP: led=0 and grant_valid=0; grant_idx holds its last value.
REQ-016 Latency: sw bit rising before edge E0 with the FSM in IDLE and enable=1 -> led valid after edge E2.
REQ-017 Grant sequence for a single persistent requester: DWELL cycles lit, 1 cycle dark, then repeat with the same index.
REQ-018 Early drop: sreq[grant_idx] falling mid-grant SHALL end the grant on the next edge; no partial dwell is credited.
REQ-019 A requester rising during GRANT or GAP SHALL be considered only at the next arbitration; it SHALL NOT preempt the current grant.
REQ-020 At most one led bit SHALL ever be high; led SHALL never change directly from one non-zero value to another.
REQ-021 The dwell counter SHALL be 8 bits and SHALL NOT wrap within a grant.

Reset
REQ-022 When rst_n=0, the following SHALL take effect immediately, independent of clk: state=IDLE, led=16'h0000, grant_valid=0, grant_idx=0, dwell counter=0, synchronizer flops=0, last_idx=15 (so that the first scan starts at index 0).
REQ-023 Reset asserted mid-grant SHALL clear led asynchronously. After release, the first grant SHALL follow REQ-016 timing relative to the first edge with rst_n=1.

Verification (DWELL=4)
REQ-024 Reset: rst_n=0 with sw=16'hFFFF and enable=1 -> led=0, grant_valid=0, grant_idx=0 throughout; after release, first grant_idx=0.
REQ-025 sw=16'h0001, enable=1 -> led=16'h0001 from the 3rd edge, held 4 cycles, then 1 cycle of 0; pattern repeats.
REQ-026 sw=16'h8001 -> grant_idx sequence 0,15,0,15; each grant lasts 4 cycles, separated by one 0 cycle; led never shows 16'h8001.
REQ-027 sw=16'h0020 granted, sw[5] cleared after 1 lit cycle -> led=0 three edges after the clear (2 synchronizer edges + 1), grant_valid=0, grant_idx stays 5.
REQ-028 enable dropped during a grant of idx 3 -> led=0 on the next edge; state stays IDLE while enable=0 even with sw=16'h0008; re-grant of idx 3 on the first edge after enable returns to 1.
REQ-029 sw=16'h0104 steady -> idx 2, 8, 2, 8 order; a new sw[0] rising mid-grant of idx 8 -> next winner is 0 (wrap), then 2.

Source files
------------

// File: rtl/led_scheduler_if.sv
// ============================================================================
//  Module      : led_scheduler_if
//  Description : Request/display bundle between a requester bank and the
//                round-robin LED scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_scheduler_if;
  logic        enable;
  logic [15:0] sw;
  logic [15:0] led;
  logic        grant_valid;
  logic [3:0]  grant_idx;

  // Requester side: drives enable and requests, observes the grant.
  modport master (
    output enable,
    output sw,
    input  led,
    input  grant_valid,
    input  grant_idx
  );

  // Scheduler side.
  modport slave (
    input  enable,
    input  sw,
    output led,
    output grant_valid,
    output grant_idx
  );
endinterface

`default_nettype wire

// File: rtl/led_scheduler.sv
// ============================================================================
//  Module      : led_scheduler
//  Description : Round-robin scheduler granting a 16-bit LED bank to one of
//                16 asynchronous requesters for DWELL cycles at a time, with
//                a one-cycle dark gap between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_scheduler #(
  parameter int DWELL = 4
) (
  input  wire             clk,
  input  wire             rst_n,
  led_scheduler_if.slave  sched_io
);

  // A DWELL of 0 is treated as a single-cycle grant.
  localparam logic [7:0] DWELL_EFF  = (DWELL == 0) ? 8'd1 : 8'(DWELL);
  localparam logic [7:0] DWELL_LAST = DWELL_EFF - 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [15:0] sync1_q;
  logic [15:0] sreq_q;
  logic [7:0]  dwell_q,       dwell_d;
  logic [3:0]  last_idx_q,    last_idx_d;
  logic [3:0]  grant_idx_q,   grant_idx_d;
  logic [15:0] led_q,         led_d;
  logic        grant_valid_q, grant_valid_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;

  // Round-robin pick: first pending request scanning upward from last_idx+1,
  // wrapping naturally through the 4-bit index (last_idx itself is checked last).
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      cand = last_idx_q + 4'(k);
      if (!win_found && sreq_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output values; GAP falls through to IDLE and
  // re-arbitrates on the same edge so IDLE costs no cycle when work is pending.
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    last_idx_d    = last_idx_q;
    grant_idx_d   = grant_idx_q;
    led_d         = 16'h0000;
    grant_valid_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        dwell_d = 8'd0;
        if (sched_io.enable && win_found) begin
          state_d       = GRANT;
          last_idx_d    = win_idx;
          grant_idx_d   = win_idx;
          led_d         = 16'h0001 << win_idx;
          grant_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if ((dwell_q == DWELL_LAST) || !sreq_q[grant_idx_q] || !sched_io.enable) begin
          state_d = GAP;
          dwell_d = 8'd0;
        end else begin
          dwell_d       = dwell_q + 8'd1;
          led_d         = 16'h0001 << grant_idx_q;
          grant_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dwell_d = 8'd0;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs; reset clears all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 16'h0000;
      sreq_q        <= 16'h0000;
      state_q       <= IDLE;
      dwell_q       <= 8'd0;
      last_idx_q    <= 4'd15;
      grant_idx_q   <= 4'd0;
      led_q         <= 16'h0000;
      grant_valid_q <= 1'b0;
    end else begin
      sync1_q       <= sched_io.sw;
      sreq_q        <= sync1_q;
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      last_idx_q    <= last_idx_d;
      grant_idx_q   <= grant_idx_d;
      led_q         <= led_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign sched_io.led         = led_q;
  assign sched_io.grant_valid = grant_valid_q;
  assign sched_io.grant_idx   = grant_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_led_scheduler.sv
// ============================================================================
//  Module      : tb_led_scheduler
//  Description : Self-checking bench for led_scheduler (DWELL=4): directed
//                scenarios followed by randomized requests, compared against
//                a grant-level behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_scheduler;

  localparam int DWELL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_scheduler_if bus ();

  led_scheduler #(.DWELL(DWELL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_io (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: requests seen two edges late, a grant is "lit" for a
  // counted number of cycles, and any edge with no lit grant may start one.
  logic [15:0] m_s1   = 16'h0000;
  logic [15:0] m_s2   = 16'h0000;
  logic [15:0] m_sreq = 16'h0000;
  int          m_lit  = -1;
  int          m_cnt  = 0;
  int          m_last = 15;
  int          m_gidx = 0;
  int          m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 16'h0000; m_s2 = 16'h0000;
      m_lit = -1; m_cnt = 0; m_last = 15; m_gidx = 0;
    end else begin
      m_sreq = m_s2;
      m_s2   = m_s1;
      m_s1   = bus.sw;
      if (m_lit >= 0) begin
        if (m_cnt >= DWELL || !m_sreq[m_lit] || !bus.enable) m_lit = -1;
        else m_cnt++;
      end else if (bus.enable && m_sreq != 16'h0000) begin
        for (int k = 1; k <= 16; k++) begin
          m_c = (m_last + k) % 16;
          if (m_sreq[m_c]) begin
            m_lit = m_c;
            break;
          end
        end
        m_cnt  = 1;
        m_last = m_lit;
        m_gidx = m_lit;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_led;
    exp_led = (m_lit >= 0) ? (16'h0001 << m_lit) : 16'h0000;
    check("led",         32'(bus.led),         32'(exp_led));
    check("grant_valid", 32'(bus.grant_valid), 32'(m_lit >= 0));
    check("grant_idx",   32'(bus.grant_idx),   32'(m_gidx));
    check("onehot",      32'($countones(bus.led) <= 1), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Advance to the first lit cycle of the next grant (bounded wait).
  task automatic next_grant(output logic [3:0] idx);
    int n;
    n = 0;
    while (bus.grant_valid && n < 40) begin cyc(); n++; end
    while (!bus.grant_valid && n < 40) begin cyc(); n++; end
    if (!bus.grant_valid) begin
      checks++;
      errors++;
      $error("FAIL next_grant_timeout observed=0 expected=1");
    end
    idx = bus.grant_idx;
  endtask

  logic [3:0] gi;

  initial begin
    bus.enable = 1'b1;
    bus.sw     = 16'hFFFF;

    // Reset held with all requests high: outputs stay cleared.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      cyc();
      check("rst_led", 32'(bus.led), 32'h0);
      check("rst_gv",  32'(bus.grant_valid), 32'h0);
      check("rst_idx", 32'(bus.grant_idx), 32'h0);
    end
    rst_n = 1'b1;
    next_grant(gi);
    check("first_grant_idx", 32'(gi), 32'd0);

    // Single requester: lit from the 3rd edge, 4 lit, 1 dark, repeat.
    bus.sw = 16'h0000;
    do_reset();
    bus.sw = 16'h0001;
    cyc(); check("lat_e1", 32'(bus.led), 32'h0);
    cyc(); check("lat_e2", 32'(bus.led), 32'h0);
    repeat (4) begin cyc(); check("dwell_lit", 32'(bus.led), 32'h1); end
    cyc(); check("gap_dark", 32'(bus.led), 32'h0);
    cyc(); check("relit", 32'(bus.led), 32'h1);

    // Two requesters at opposite ends alternate.
    bus.sw = 16'h8001;
    do_reset();
    next_grant(gi); check("rr_a", 32'(gi), 32'd0);
    next_grant(gi); check("rr_b", 32'(gi), 32'd15);
    next_grant(gi); check("rr_c", 32'(gi), 32'd0);
    next_grant(gi); check("rr_d", 32'(gi), 32'd15);

    // Early drop after one lit cycle.
    bus.sw = 16'h0020;
    do_reset();
    next_grant(gi);
    bus.sw = 16'h0000;
    cyc(); check("drop_c0", 32'(bus.led), 32'h20);
    cyc(); check("drop_c1", 32'(bus.led), 32'h20);
    cyc(); check("drop_led", 32'(bus.led), 32'h0);
    check("drop_gv",  32'(bus.grant_valid), 32'h0);
    check("drop_idx", 32'(bus.grant_idx), 32'd5);

    // Enable removed mid-grant, then restored.
    bus.sw = 16'h0008;
    do_reset();
    next_grant(gi); check("en_idx", 32'(gi), 32'd3);
    bus.enable = 1'b0;
    cyc(); check("en_off_led", 32'(bus.led), 32'h0);
    repeat (4) begin cyc(); check("en_off_gv", 32'(bus.grant_valid), 32'h0); end
    bus.enable = 1'b1;
    cyc(); check("en_back_led", 32'(bus.led), 32'h0008);

    // Wrap-around: a new low requester is served after the current high one.
    bus.sw = 16'h0104;
    do_reset();
    next_grant(gi); check("wrap_a", 32'(gi), 32'd2);
    next_grant(gi); check("wrap_b", 32'(gi), 32'd8);
    bus.sw = 16'h0105;
    next_grant(gi); check("wrap_c", 32'(gi), 32'd0);
    next_grant(gi); check("wrap_d", 32'(gi), 32'd2);

    // Asynchronous reset mid-grant clears the display without a clock edge.
    bus.sw = 16'h0001;
    do_reset();
    next_grant(gi);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(bus.led), 32'h0);
    check("async_gv",  32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    cyc();
    rst_n = 1'b1;

    // Randomized requests and enable against the model.
    bus.sw = 16'h0000;
    do_reset();
    repeat (800) begin
      if ($urandom_range(0, 5) == 0)
        bus.sw = 16'($urandom) & 16'($urandom) & 16'($urandom);
      bus.enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
